// File: rtl/baud_frac_gen.sv
// Fractional-N baud tick generator: emits an oversample tick every div + frac/2^FRAC_W cycles
// and a bit tick every OVS oversample ticks, with a runtime-reloadable divisor and phase sync.
module baud_frac_gen #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned FRAC_W    = 4,
   parameter int unsigned OVS       = 16,
   parameter int unsigned DIV_INIT  = 2604,
   parameter int unsigned FRAC_INIT = 3
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    en,
   input  logic                    sync,
   input  logic [CNT_W-1:0]        cfg_div,
   input  logic [FRAC_W-1:0]       cfg_frac,
   input  logic                    cfg_valid,
   output logic                    cfg_ready,
   output logic                    ovs_tick,
   output logic                    bit_tick,
   output logic [$clog2(OVS)-1:0]  ovs_phase
);

   localparam int unsigned PH_W = $clog2(OVS);

   localparam logic [CNT_W-1:0]  DivInit  = CNT_W'(DIV_INIT);
   localparam logic [FRAC_W-1:0] FracInit = FRAC_W'(FRAC_INIT);
   localparam logic [CNT_W-1:0]  DivMin   = CNT_W'(2);
   localparam logic [PH_W-1:0]   PhLast   = PH_W'(OVS - 1);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  div_a_q, div_a_d, div_s_q, div_s_d;
   logic [FRAC_W-1:0] frac_a_q, frac_a_d, frac_s_q, frac_s_d;
   logic              pend_q, pend_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              ovs_tick_q, ovs_tick_d;
   logic              bit_tick_q, bit_tick_d;
   logic              cfg_ready_q, cfg_ready_d;

   logic              boundary, apply, xfer, carry;
   logic [FRAC_W-1:0] acc_sum;

   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      div_a_d    = div_a_q;
      frac_a_d   = frac_a_q;
      div_s_d    = div_s_q;
      frac_s_d   = frac_s_q;
      pend_d     = pend_q;
      phase_d    = phase_q;
      ovs_tick_d = 1'b0;
      bit_tick_d = 1'b0;

      boundary         = en && !sync && (cnt_q == '0);
      // cfg_ready mirrors !pend, so a transfer and an apply can never share an edge
      apply            = pend_q && (sync || !en || boundary);
      xfer             = cfg_valid && cfg_ready_q;
      {carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac_a_q};

      if (sync) begin
         cnt_d   = div_a_q - 1'b1;
         acc_d   = '0;
         phase_d = '0;
      end else if (en) begin
         if (boundary) begin
            ovs_tick_d = 1'b1;
            acc_d      = acc_sum;
            cnt_d      = div_a_q - 1'b1 + CNT_W'(carry);
            if (phase_q == PhLast) begin
               phase_d    = '0;
               bit_tick_d = 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      if (apply) begin
         div_a_d  = div_s_q;
         frac_a_d = frac_s_q;
         acc_d    = '0;
         cnt_d    = div_s_q - 1'b1;
         pend_d   = 1'b0;
      end

      if (xfer) begin
         div_s_d  = (cfg_div < DivMin) ? DivMin : cfg_div;
         frac_s_d = cfg_frac;
         pend_d   = 1'b1;
      end

      cfg_ready_d = !pend_d;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cnt_q       <= DivInit - 1'b1;
         acc_q       <= '0;
         div_a_q     <= DivInit;
         frac_a_q    <= FracInit;
         div_s_q     <= DivInit;
         frac_s_q    <= FracInit;
         pend_q      <= 1'b0;
         phase_q     <= '0;
         ovs_tick_q  <= 1'b0;
         bit_tick_q  <= 1'b0;
         cfg_ready_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         div_a_q     <= div_a_d;
         frac_a_q    <= frac_a_d;
         div_s_q     <= div_s_d;
         frac_s_q    <= frac_s_d;
         pend_q      <= pend_d;
         phase_q     <= phase_d;
         ovs_tick_q  <= ovs_tick_d;
         bit_tick_q  <= bit_tick_d;
         cfg_ready_q <= cfg_ready_d;
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign ovs_tick  = ovs_tick_q;
   assign bit_tick  = bit_tick_q;
   assign ovs_phase = phase_q;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Scoreboard bench for baud_frac_gen: expected tick edges are queued as stimulus is planned and
// popped by a monitor whenever ovs_tick is observed.
module tb_baud_frac_gen;

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned FRAC_W    = 4;
   localparam int unsigned OVS       = 16;
   localparam int unsigned DIV_INIT  = 2604;
   localparam int unsigned FRAC_INIT = 3;

   logic              clk = 1'b0;
   logic              rst_n, en, sync, cfg_valid, cfg_ready, ovs_tick, bit_tick;
   logic [CNT_W-1:0]  cfg_div;
   logic [FRAC_W-1:0] cfg_frac;
   logic [3:0]        ovs_phase;

   baud_frac_gen #(
      .CNT_W     (CNT_W),
      .FRAC_W    (FRAC_W),
      .OVS       (OVS),
      .DIV_INIT  (DIV_INIT),
      .FRAC_INIT (FRAC_INIT)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .en        (en),
      .sync      (sync),
      .cfg_div   (cfg_div),
      .cfg_frac  (cfg_frac),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .ovs_tick  (ovs_tick),
      .bit_tick  (bit_tick),
      .ovs_phase (ovs_phase)
   );

   always #5 clk = ~clk;

   // cyc = number of rising edges so far; stable when read at the falling edge
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int   at;
      logic bt;
      int   ph;
   } tick_t;

   tick_t exp_q[$];
   int    seen_q[$];

   int m_next, m_div, m_frac, m_acc, m_phase, m_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Counter reloaded to div-1 at edge 'at': first boundary div edges later, acc cleared.
   task automatic m_start(input int at, input int div, input int frac);
      m_next = at + div;
      m_div  = div;
      m_frac = frac;
      m_acc  = 0;
   endtask

   task automatic m_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         tick_t t;
         m_phase = (m_phase + 1) % OVS;
         t.at = m_next;
         t.bt = (m_phase == 0);
         t.ph = m_phase;
         exp_q.push_back(t);
         m_last = m_next;
         m_acc  = m_acc + m_frac;
         m_next = m_next + m_div + (m_acc >> FRAC_W);
         m_acc  = m_acc % (2 ** FRAC_W);
      end
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   // Offer a config with en low; returns the edge at which it was applied.
   task automatic load(input int div, input int frac, output int applied);
      cfg_div   = CNT_W'(div);
      cfg_frac  = FRAC_W'(frac);
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("ready_pending", cfg_ready, 0);
      @(negedge clk);
      check("ready_applied", cfg_ready, 1);
      applied = cyc;
   endtask

   always @(negedge clk) begin
      if (ovs_tick === 1'b1) begin
         seen_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("tick_unexpected", exp_q.size(), 1);
         end else begin
            tick_t t;
            t = exp_q.pop_front();
            check("tick_at", cyc, t.at);
            check("bit_tick", bit_tick, t.bt);
            check("ovs_phase", ovs_phase, t.ph);
         end
      end else if (cyc > 0 && bit_tick !== 1'b0) begin
         check("bit_without_ovs", bit_tick, 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: stuck at cycle %0d, expected end before %0d", cyc, 50000);
      $fatal(1, "watchdog");
   end

   initial begin
      int a, l, s, u, v, r;
      rst_n     = 1'b0;
      en        = 1'b0;
      sync      = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = '0;
      cfg_frac  = '0;
      m_phase   = 0;

      // Reset state, then default divisor with en high from the first edge
      wait_cyc(2);
      check("rst_ovs_tick", ovs_tick, 0);
      check("rst_bit_tick", bit_tick, 0);
      check("rst_phase", ovs_phase, 0);
      check("rst_ready", cfg_ready, 0);
      rst_n = 1'b1;
      en    = 1'b1;
      r     = cyc;
      m_start(r, DIV_INIT, FRAC_INIT);
      m_ticks(2);
      wait_cyc(r + 1);
      check("ready_after_rst", cfg_ready, 1);
      wait_cyc(m_last);
      en = 1'b0;

      // Integer divide by 10, long enough for two bit ticks
      load(10, 0, a);
      m_start(a, 10, 0);
      en = 1'b1;
      m_ticks(35);

      // Runtime reload to 4 offered mid-period; a second offer must be refused
      l = m_last - 10;
      wait_cyc(l + 3);
      cfg_div   = 16'd4;
      cfg_frac  = 4'd0;
      cfg_valid = 1'b1;
      wait_cyc(l + 4);
      cfg_valid = 1'b0;
      check("reload_ready_lo", cfg_ready, 0);
      wait_cyc(l + 6);
      cfg_div   = 16'd7;
      cfg_frac  = 4'd5;
      cfg_valid = 1'b1;
      wait_cyc(l + 9);
      check("reload_ready_hold", cfg_ready, 0);
      wait_cyc(l + 10);
      cfg_valid = 1'b0;
      check("reload_ready_hi", cfg_ready, 1);
      m_start(l + 10, 4, 0);
      m_ticks(8);
      wait_cyc(m_last);
      en = 1'b0;

      // Clamp: divisor 0 behaves as 2
      load(0, 0, a);
      m_start(a, 2, 0);
      en = 1'b1;
      m_ticks(6);
      for (int i = 1; i <= 4; i++) begin
         wait_cyc(a + i);
         check("clamp_pattern", ovs_tick, (i % 2 == 0) ? 1 : 0);
      end
      wait_cyc(m_last);
      en = 1'b0;

      // Fractional divide 10 + 8/16
      load(10, 8, a);
      seen_q.delete();
      m_start(a, 10, 8);
      en = 1'b1;
      m_ticks(34);
      wait_cyc(m_last);
      s = m_last;
      @(negedge clk);
      check("frac_32_periods", seen_q[32] - seen_q[0], 336);

      // sync three cycles after a tick restarts the phase
      wait_cyc(s + 2);
      sync = 1'b1;
      wait_cyc(s + 3);
      sync = 1'b0;
      check("sync_phase", ovs_phase, 0);
      check("sync_no_tick", ovs_tick, 0);
      m_phase = 0;
      m_start(s + 3, 10, 8);
      m_ticks(3);

      // Five-cycle pause mid-period delays the next tick by five
      wait_cyc(m_last);
      u = m_last;
      wait_cyc(u + 3);
      en     = 1'b0;
      m_next = m_next + 5;
      m_ticks(2);
      wait_cyc(u + 8);
      en = 1'b1;

      // Reset mid-period with a config pending; defaults must come back
      wait_cyc(m_last);
      v = m_last;
      wait_cyc(v + 1);
      cfg_div   = 16'd5;
      cfg_frac  = 4'd0;
      cfg_valid = 1'b1;
      wait_cyc(v + 2);
      cfg_valid = 1'b0;
      check("pend_before_rst", cfg_ready, 0);
      wait_cyc(v + 4);
      rst_n = 1'b0;
      wait_cyc(v + 5);
      check("rst2_ovs_tick", ovs_tick, 0);
      check("rst2_bit_tick", bit_tick, 0);
      check("rst2_phase", ovs_phase, 0);
      check("rst2_ready", cfg_ready, 0);
      rst_n = 1'b1;
      r     = cyc;
      m_phase = 0;
      m_start(r, DIV_INIT, FRAC_INIT);
      m_ticks(2);
      wait_cyc(r + 1);
      check("ready_after_rst2", cfg_ready, 1);
      wait_cyc(m_last);
      en = 1'b0;
      @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
